// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the product accumulator.
package mult_acc_pkg;

    localparam int P_W_DEF   = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_product_accumulator.sv
// Sums len_i consecutive multiplier products and presents the total on a valid/ready port.
// Define MULT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module mult_product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [P_W-1:0]   prod_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    output logic [ACC_W-1:0] sum_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             busy_o,
    output logic             ovf_o
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] add_res;
    logic             last_term;

    always_comb begin
        prod_ext           = '0;
        prod_ext[P_W-1:0]  = prod_i;
    end

    assign add_full = {1'b0, acc_q} + prod_ext;

`ifdef MULT_ACC_SAT_EN
    // once saturated, any further add carries out again, so all-ones is sticky
    assign add_res = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];
`else
    assign add_res = add_full[ACC_W-1:0];
`endif

    // len_q is never 0 in ACC, so cnt stops at len_q-1 and never wraps
    assign last_term = (cnt_q == (len_q - CNT_W'(1)));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        len_d   = len_i;
                        cnt_d   = '0;
                        state_d = ACC;
                    end else begin
                        sum_d   = '0;
                        state_d = OUT;
                    end
                end
            end
            ACC: begin
                if (prod_valid_i) begin
                    acc_d = add_res;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (add_full[ACC_W]) ovf_d = 1'b1;
                    if (last_term) begin
                        sum_d   = add_res;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (sum_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_ready_o = (state_q == ACC);
    assign sum_valid_o  = (state_q == OUT);
    assign busy_o       = (state_q != IDLE);
    assign sum_o        = sum_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench: default-width instance for the main sums, a 16-bit accumulator instance for overflow.
module tb_mult_product_accumulator;

    localparam int P_W     = 16;
    localparam int ACC_W   = 24;
    localparam int CNT_W   = 8;
    localparam int B_ACC_W = 16;

`ifdef MULT_ACC_SAT_EN
    localparam logic [B_ACC_W-1:0] B_OVF_SUM = 16'hFFFF;
`else
    localparam logic [B_ACC_W-1:0] B_OVF_SUM = 16'h0001;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               a_start, a_pv, a_pr, a_sv, a_sr, a_busy, a_ovf;
    logic [CNT_W-1:0]   a_len;
    logic [P_W-1:0]     a_prod;
    logic [ACC_W-1:0]   a_sum;

    logic               b_start, b_pv, b_pr, b_sv, b_sr, b_busy, b_ovf;
    logic [CNT_W-1:0]   b_len;
    logic [P_W-1:0]     b_prod;
    logic [B_ACC_W-1:0] b_sum;

    mult_product_accumulator #(.P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .len_i(a_len), .prod_i(a_prod),
        .prod_valid_i(a_pv), .prod_ready_o(a_pr), .sum_o(a_sum), .sum_valid_o(a_sv),
        .sum_ready_i(a_sr), .busy_o(a_busy), .ovf_o(a_ovf)
    );

    mult_product_accumulator #(.P_W(P_W), .ACC_W(B_ACC_W), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .len_i(b_len), .prod_i(b_prod),
        .prod_valid_i(b_pv), .prod_ready_o(b_pr), .sum_o(b_sum), .sum_valid_o(b_sv),
        .sum_ready_i(b_sr), .busy_o(b_busy), .ovf_o(b_ovf)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [ACC_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic a_go(input int len);
        a_start = 1'b1;
        a_len   = len[CNT_W-1:0];
        step();
        a_start = 1'b0;
    endtask

    task automatic a_feed(input logic [P_W-1:0] p);
        a_pv   = 1'b1;
        a_prod = p;
        step();
        a_pv   = 1'b0;
    endtask

    // called the cycle after the last accept: result must already be valid
    task automatic a_result(input string tag, input logic exp_ovf);
        logic [ACC_W-1:0] e;
        e = 'x;
        chk({tag, "_valid"}, a_sv, 1);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, a_sum, e);
        end
        chk({tag, "_ovf"}, a_ovf, exp_ovf);
        a_sr = 1'b1;
        step();
        a_sr = 1'b0;
        chk({tag, "_idle"}, a_busy, 0);
        chk({tag, "_hold"}, a_sum, e);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 0; a_len = '0; a_prod = '0; a_pv = 0; a_sr = 0;
        b_start = 0; b_len = '0; b_prod = '0; b_pv = 0; b_sr = 0;
        step(); step();
        chk("rst_sum",   a_sum,  0);
        chk("rst_valid", a_sv,   0);
        chk("rst_ready", a_pr,   0);
        chk("rst_busy",  a_busy, 0);
        chk("rst_ovf",   a_ovf,  0);
        chk("rst_b_sum", b_sum,  0);
        rst = 1'b0;
        step();

        // basic dot product
        a_go(3);
        chk("t1_ready", a_pr, 1);
        chk("t1_busy", a_busy, 1);
        exp_q.push_back(24'd271);
        a_feed(16'd6);
        a_feed(16'd10);
        chk("t1_mid_valid", a_sv, 0);
        a_feed(16'd255);
        a_result("t1", 1'b0);

        // gapped input then backpressure
        a_go(2);
        exp_q.push_back(24'h010000);
        a_feed(16'hFFFF);
        step();
        chk("t2_gap_ready", a_pr, 1);
        chk("t2_gap_valid", a_sv, 0);
        step();
        a_feed(16'h0001);
        for (int i = 0; i < 4; i++) begin
            a_pv   = 1'b1;
            a_prod = 16'd7;
            chk("t2_stall_sum", a_sum, 32'h010000);
            chk("t2_stall_valid", a_sv, 1);
            chk("t2_stall_ready", a_pr, 0);
            step();
        end
        a_pv = 1'b0;
        a_result("t2", 1'b0);

        // reset mid-sum discards the partial total
        a_go(4);
        a_feed(16'd100);
        a_feed(16'd200);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_sum",   a_sum,  0);
        chk("t5_rst_valid", a_sv,   0);
        chk("t5_rst_ready", a_pr,   0);
        chk("t5_rst_busy",  a_busy, 0);
        step();
        rst = 1'b0;
        step();
        a_go(1);
        exp_q.push_back(24'd9);
        a_feed(16'd9);
        a_result("t5", 1'b0);

        // zero length with product valid held high
        a_pv   = 1'b1;
        a_prod = 16'd55;
        a_go(0);
        exp_q.push_back(24'd0);
        chk("t3_ready", a_pr, 0);
        a_result("t3", 1'b0);
        chk("t3_ready_after", a_pr, 0);
        a_pv = 1'b0;

        // start while accumulating is dropped
        a_go(2);
        exp_q.push_back(24'd12);
        a_feed(16'd5);
        a_start = 1'b1;
        a_len   = 8'd5;
        a_feed(16'd7);
        a_start = 1'b0;
        a_result("t6", 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_second_busy", a_busy, 0);
            chk("t6_no_second_valid", a_sv, 0);
            step();
        end

        // maximum length: count must reach 255 without wrapping
        a_go(255);
        exp_q.push_back(24'd32640);
        for (int i = 1; i <= 255; i++) begin
            if (i == 255) begin
                chk("t7_pre_last_ready", a_pr, 1);
                chk("t7_pre_last_valid", a_sv, 0);
            end
            a_feed(P_W'(i));
        end
        a_result("t7", 1'b0);

        // overflow on the 16-bit accumulator
        b_start = 1'b1;
        b_len   = 8'd2;
        step();
        b_start = 1'b0;
        b_pv    = 1'b1;
        b_prod  = 16'hFFFF;
        step();
        b_prod  = 16'h0002;
        step();
        b_pv    = 1'b0;
        chk("t4_valid", b_sv, 1);
        chk("t4_sum", b_sum, B_OVF_SUM);
        chk("t4_ovf", b_ovf, 1);
        b_sr = 1'b1;
        step();
        b_sr = 1'b0;
        chk("t4_ovf_sticky", b_ovf, 1);
        b_start = 1'b1;
        b_len   = 8'd1;
        step();
        b_start = 1'b0;
        chk("t4_ovf_cleared", b_ovf, 0);
        b_pv   = 1'b1;
        b_prod = 16'h0001;
        step();
        b_pv   = 1'b0;
        chk("t4_next_sum", b_sum, 1);
        chk("t4_next_ovf", b_ovf, 0);
        b_sr = 1'b1;
        step();
        b_sr = 1'b0;

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mult_product_accumulator.md
# mult_product_accumulator

Downstream consumer of the shift-and-add multiplier's product stream. It sums a programmed number of consecutive products, such as a dot-product term count, into a wide accumulator. It then presents the total on a valid/ready output with backpressure. It turns the multiplier into a MAC path without modifying it.

## Interface
- P_W, 16, product width; matches multiplier m+n
- ACC_W, 24, accumulator / sum width; must be ≥ P_W
- CNT_W, 8, width of term-count field
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start_i  input  1  begin a new sum; sampled only in IDLE
- len_i  input  CNT_W  number of products to sum; sampled with start_i
- prod_i  input  P_W  product from multiplier (unsigned)
- prod_valid_i  input  1  prod_i valid
- prod_ready_o  output  1  product accepted when valid & ready
- sum_o  output  ACC_W  accumulated sum
- sum_valid_o  output  1  sum_o valid
- sum_ready_i  input  1  downstream accepts sum
- busy_o  output  1  state ≠ IDLE
- ovf_o  output  1  sticky: current sum overflowed ACC_W

## Operation
- States:
  - IDLE, ACC, OUT. State and all outputs are registered, except prod_ready_o, sum_valid_o and busy_o, which decode directly from the state register.
- IDLE:
  - If start_i = 1 and len_i ≠ 0: latch len_i into len_q, clear acc and cnt, clear ovf_o, go to ACC.
  - If start_i = 1 and len_i = 0: clear acc and ovf_o, go straight to OUT.
- ACC:
  - prod_ready_o = 1.
  - On each prod_valid_i & prod_ready_o: acc ← acc + zero-extended prod_i, and cnt ← cnt + 1.
  - When the accepted product is number len_q (cnt = len_q−1 before the increment), go to OUT.
- OUT:
  - sum_valid_o = 1 and sum_o = acc, held stable until handshake.
  - On sum_ready_i: go to IDLE. sum_o keeps its last value; ovf_o keeps its value until the next start.
- Arithmetic:
  - Unsigned. The add is computed at ACC_W+1 bits.
  - If the carry-out is 1, ovf_o is set (sticky) and the sum behaves as defined in Configuration.
- start_i outside IDLE is ignored (not queued).
- prod_valid_i outside ACC: prod_ready_o = 0, so nothing is consumed.
- len_i = 2^CNT_W−1 is legal; cnt must not wrap before the terminal compare.

## Timing
- Reset values:
  - State IDLE.
  - sum_o = 0, sum_valid_o = 0, prod_ready_o = 0, busy_o = 0, ovf_o = 0.
  - acc, cnt, len_q = 0.
- Latency to ACC: start_i at edge k gives prod_ready_o = 1 from cycle k+1.
- Throughput: one product per cycle while in ACC.
- Latency to result: last product accepted at edge k gives sum_valid_o = 1 in cycle k+1.
- len_i = 0: sum_valid_o = 1 with sum_o = 0 in the cycle after start.
- Minimum cycle turnaround: sum handshake at edge k puts the block in IDLE in cycle k+1. A start_i in cycle k+1 is therefore accepted; a start in cycle k (while in OUT) is dropped.
- Reset mid-operation: the partial sum is discarded and all outputs return to reset values asynchronously.

## Configuration
- MULT_ACC_SAT_EN defined:
  - On carry-out, acc saturates to all-ones (2^ACC_W−1) and stays there for the rest of the sum.
  - ovf_o is set.
- MULT_ACC_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf_o is still set.

## Structure
- Package mult_acc_pkg holds:
  - the state enum (IDLE, ACC, OUT);
  - the default-width constants P_W_DEF = 16, ACC_W_DEF = 24, CNT_W_DEF = 8.
- No sub-module is required. The saturating/wrapping adder is inline logic selected by the macro.

## Test plan
- Basic dot product: start, len=3; products 6, 10, 255 on consecutive cycles.
  - Expect sum_o = 271 with sum_valid_o one cycle after the third accept; ovf_o = 0.
- Gapped input and backpressure: len=2; products 0xFFFF, then 1 with two idle cycles between them; sum_ready_i low for 4 cycles.
  - Expect sum_o = 0x010000 held stable throughout, and no further product accepted.
- Zero length: start with len=0 and prod_valid_i held high.
  - Expect sum_valid_o = 1 and sum_o = 0 the next cycle; prod_ready_o never asserted.
- Overflow, ACC_W=16, len=2, products 0xFFFF and 0x0002:
  - without MULT_ACC_SAT_EN, sum_o = 0x0001 and ovf_o = 1;
  - with MULT_ACC_SAT_EN, sum_o = 0xFFFF and ovf_o = 1.
- Reset mid-sum: len=4, rst asserted after 2 accepts.
  - Expect all outputs 0 immediately and state IDLE.
  - A new start with len=1, product 9, then gives sum_o = 9.
- Ignored start: pulse start_i with len=5 while in ACC on a len=2 sum.
  - Expect the sum to complete after 2 products and no second sum.
